sync_fifo_nw_1r: RTL and testbench

SYNC_FIFO_NW_1R -- requirements
Module: sync_fifo_nw_1r

---
 rtl/sync_fifo_nw_1r.sv | 128 ++++++++++++
 tb/tb_sync_fifo_nw_1r.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_nw_1r.sv
// Synchronous FIFO, up to two write lanes per cycle, one registered read port.
// Define SYNC_FIFO_ERR_FLAGS_EN to build the sticky overflow/underflow flags.
module sync_fifo_nw_1r #(
  parameter int DATA_WIDTH    = 65,
  parameter int ADDRESS_WIDTH = 4,
  parameter int WR_PORTS      = 2,
  parameter int AF_MARGIN     = 2
) (
  input  logic                           Clk,
  input  logic                           Clear_n_in,
  input  logic [WR_PORTS*DATA_WIDTH-1:0] Data_in,
  input  logic [1:0]                     WriteCnt_in,
  input  logic                           ReadEn_in,
  output logic [DATA_WIDTH-1:0]          Data_out,
  output logic                           Data_valid,
  output logic                           Empty_out,
  output logic                           Full_out,
  output logic                           AlmostFull_out,
  output logic [ADDRESS_WIDTH:0]         Count_out,
  output logic                           Overflow_out,
  output logic                           Underflow_out
);

  localparam int FIFO_DEPTH = 1 << ADDRESS_WIDTH;
  localparam int CW = ADDRESS_WIDTH + 1;
  localparam int AW = ADDRESS_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic          dvld_q, dvld_d;

  logic [CW-1:0] free;
  logic          wr_acc;
  logic          pop;
  logic          empty;
  logic [AW-1:0] lane_addr [WR_PORTS];
  logic          lane_we   [WR_PORTS];

  assign empty = (count_q == '0);
  assign free  = CW'(FIFO_DEPTH) - count_q;

  // Acceptance looks only at pre-edge occupancy; a same-cycle pop frees nothing.
  assign wr_acc = (int'(WriteCnt_in) <= WR_PORTS) &&
                  (CW'(WriteCnt_in) <= free);
  assign pop    = ReadEn_in && !empty;

  always_comb begin
    for (int k = 0; k < WR_PORTS; k++) begin
      lane_addr[k] = wr_ptr_q + AW'(k);
      lane_we[k]   = wr_acc && (int'(WriteCnt_in) > k);
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    dout_d   = dout_q;
    dvld_d   = 1'b0;
    if (wr_acc) begin
      wr_ptr_d = wr_ptr_q + AW'(WriteCnt_in);
      count_d  = count_q + CW'(WriteCnt_in);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
      count_d  = count_d - CW'(1);
      dout_d   = mem_q[rd_ptr_q];
      dvld_d   = 1'b1;
    end
  end

  always_ff @(posedge Clk or negedge Clear_n_in) begin
    if (!Clear_n_in) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      dout_q   <= '0;
      dvld_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      dout_q   <= dout_d;
      dvld_q   <= dvld_d;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge Clk) begin
    for (int k = 0; k < WR_PORTS; k++) begin
      if (lane_we[k]) begin
        mem_q[lane_addr[k]] <= Data_in[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign Data_out       = dout_q;
  assign Data_valid     = dvld_q;
  assign Count_out      = count_q;
  assign Empty_out      = empty;
  assign Full_out       = int'(free) < WR_PORTS;
  assign AlmostFull_out = int'(free) <= AF_MARGIN;

`ifdef SYNC_FIFO_ERR_FLAGS_EN
  logic ovf_q, unf_q;

  always_ff @(posedge Clk or negedge Clear_n_in) begin
    if (!Clear_n_in) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_q | !wr_acc;
      unf_q <= unf_q | (ReadEn_in && empty);
    end
  end

  assign Overflow_out  = ovf_q;
  assign Underflow_out = unf_q;
`else
  assign Overflow_out  = 1'b0;
  assign Underflow_out = 1'b0;
`endif

endmodule

// File: tb/tb_sync_fifo_nw_1r.sv
// Directed bench for sync_fifo_nw_1r (depth 16, two write lanes, 65-bit data).
module tb_sync_fifo_nw_1r;

  localparam int DW = 65;

  logic          Clk;
  logic          Clear_n_in;
  logic [2*DW-1:0] Data_in;
  logic [1:0]    WriteCnt_in;
  logic          ReadEn_in;
  logic [DW-1:0] Data_out;
  logic          Data_valid;
  logic          Empty_out;
  logic          Full_out;
  logic          AlmostFull_out;
  logic [4:0]    Count_out;
  logic          Overflow_out;
  logic          Underflow_out;

  int tests = 0;
  int fails = 0;

`ifdef SYNC_FIFO_ERR_FLAGS_EN
  localparam logic FLAG_ON = 1'b1;
`else
  localparam logic FLAG_ON = 1'b0;
`endif

  sync_fifo_nw_1r #(
    .DATA_WIDTH(DW),
    .ADDRESS_WIDTH(4),
    .WR_PORTS(2),
    .AF_MARGIN(2)
  ) dut (
    .Clk(Clk),
    .Clear_n_in(Clear_n_in),
    .Data_in(Data_in),
    .WriteCnt_in(WriteCnt_in),
    .ReadEn_in(ReadEn_in),
    .Data_out(Data_out),
    .Data_valid(Data_valid),
    .Empty_out(Empty_out),
    .Full_out(Full_out),
    .AlmostFull_out(AlmostFull_out),
    .Count_out(Count_out),
    .Overflow_out(Overflow_out),
    .Underflow_out(Underflow_out)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [DW-1:0] obs,
                     input logic [DW-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic [1:0] n, input logic [DW-1:0] a,
                     input logic [DW-1:0] b, input logic re);
    WriteCnt_in = n;
    Data_in     = {b, a};
    ReadEn_in   = re;
    @(posedge Clk);
    #1;
    WriteCnt_in = 2'd0;
    Data_in     = '0;
    ReadEn_in   = 1'b0;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_cnt"}, DW'(Count_out), DW'(0));
    chk({tag, "_vld"}, DW'(Data_valid), DW'(0));
    chk({tag, "_dout"}, Data_out, DW'(0));
    chk({tag, "_empty"}, DW'(Empty_out), DW'(1));
    chk({tag, "_full"}, DW'(Full_out), DW'(0));
    chk({tag, "_af"}, DW'(AlmostFull_out), DW'(0));
    chk({tag, "_ovf"}, DW'(Overflow_out), DW'(0));
    chk({tag, "_unf"}, DW'(Underflow_out), DW'(0));
  endtask

  localparam logic [DW-1:0] VA = 65'h1_0000_0000_0000_00AA;
  localparam logic [DW-1:0] VB = 65'h0_FFFF_FFFF_FFFF_FFBB;

  initial begin
    logic [DW-1:0] e;
    int exp_idx;
    Clear_n_in  = 1'b1;
    Data_in     = '0;
    WriteCnt_in = 2'd0;
    ReadEn_in   = 1'b0;
    #1 Clear_n_in = 1'b0;
    #1;
    chk_reset("rst");
    #10 Clear_n_in = 1'b1;

    // basic two-lane write, two pops in lane order
    cyc(2'd2, VA, VB, 1'b0);
    chk("w2_cnt", DW'(Count_out), DW'(2));
    chk("w2_empty", DW'(Empty_out), DW'(0));
    cyc(2'd0, '0, '0, 1'b1);
    chk("pop1_d", Data_out, VA);
    chk("pop1_v", DW'(Data_valid), DW'(1));
    cyc(2'd0, '0, '0, 1'b1);
    chk("pop2_d", Data_out, VB);
    chk("pop2_v", DW'(Data_valid), DW'(1));
    chk("pop2_empty", DW'(Empty_out), DW'(1));

    // pop while empty
    cyc(2'd0, '0, '0, 1'b1);
    chk("uf_v", DW'(Data_valid), DW'(0));
    chk("uf_d", Data_out, VB);
    chk("uf_flag", DW'(Underflow_out), DW'(FLAG_ON));
    chk("uf_cnt", DW'(Count_out), DW'(0));

    // fill to 15, overflow rejection, then fill to 16
    for (int i = 0; i < 7; i++) begin
      cyc(2'd2, DW'(100 + 2*i), DW'(101 + 2*i), 1'b0);
    end
    chk("c14_cnt", DW'(Count_out), DW'(14));
    chk("c14_full", DW'(Full_out), DW'(0));
    chk("c14_af", DW'(AlmostFull_out), DW'(1));
    chk("c14_ovf", DW'(Overflow_out), DW'(0));
    cyc(2'd1, DW'(114), '0, 1'b0);
    chk("c15_cnt", DW'(Count_out), DW'(15));
    chk("c15_full", DW'(Full_out), DW'(1));
    cyc(2'd2, DW'(500), DW'(501), 1'b0);
    chk("rej_cnt", DW'(Count_out), DW'(15));
    chk("rej_ovf", DW'(Overflow_out), DW'(FLAG_ON));
    cyc(2'd1, DW'(200), '0, 1'b0);
    chk("c16_cnt", DW'(Count_out), DW'(16));
    chk("c16_full", DW'(Full_out), DW'(1));

    // full: write + pop same cycle, write still rejected
    cyc(2'd1, DW'(600), '0, 1'b1);
    chk("fwp_cnt", DW'(Count_out), DW'(15));
    chk("fwp_d", Data_out, DW'(100));
    chk("fwp_v", DW'(Data_valid), DW'(1));
    for (int i = 0; i < 15; i++) begin
      cyc(2'd0, '0, '0, 1'b1);
      e = (i == 14) ? DW'(200) : DW'(101 + i);
      chk("drain1_d", Data_out, e);
    end
    chk("drain1_empty", DW'(Empty_out), DW'(1));

    // simultaneous write pair and pop at count 8
    for (int i = 0; i < 4; i++) begin
      cyc(2'd2, DW'(300 + 2*i), DW'(301 + 2*i), 1'b0);
    end
    chk("c8_cnt", DW'(Count_out), DW'(8));
    cyc(2'd2, DW'(400), DW'(401), 1'b1);
    chk("rw_cnt", DW'(Count_out), DW'(9));
    chk("rw_v", DW'(Data_valid), DW'(1));
    chk("rw_d", Data_out, DW'(300));
    for (int i = 0; i < 9; i++) begin
      cyc(2'd0, '0, '0, 1'b1);
      e = (i < 7) ? DW'(301 + i) : DW'(400 + i - 7);
      chk("drain2_d", Data_out, e);
    end
    chk("drain2_cnt", DW'(Count_out), DW'(0));

    // 40 pairs with continuous pops across pointer wrap
    exp_idx = 0;
    for (int i = 0; i < 80; i++) begin
      if (i % 2 == 0) begin
        cyc(2'd2, DW'(1000 + i), DW'(1001 + i), 1'b1);
      end else begin
        cyc(2'd0, '0, '0, 1'b1);
      end
      if (Data_valid) begin
        chk("stream_d", Data_out, DW'(1000 + exp_idx));
        exp_idx++;
      end
    end
    for (int i = 0; i < 4; i++) begin
      cyc(2'd0, '0, '0, 1'b1);
      if (Data_valid) begin
        chk("stream_d", Data_out, DW'(1000 + exp_idx));
        exp_idx++;
      end
    end
    chk("stream_total", DW'(exp_idx), DW'(80));
    chk("stream_empty", DW'(Empty_out), DW'(1));

    // asynchronous reset mid-stream at count 5
    cyc(2'd2, DW'(700), DW'(701), 1'b0);
    cyc(2'd2, DW'(702), DW'(703), 1'b0);
    cyc(2'd2, DW'(704), DW'(705), 1'b1);
    chk("pre_rst_cnt", DW'(Count_out), DW'(5));
    chk("pre_rst_d", Data_out, DW'(700));
    #2 Clear_n_in = 1'b0;
    #1;
    chk_reset("async");
    #2 Clear_n_in = 1'b1;
    cyc(2'd1, VA ^ DW'(55), '0, 1'b0);
    chk("post_cnt", DW'(Count_out), DW'(1));
    cyc(2'd0, '0, '0, 1'b1);
    chk("post_d", Data_out, VA ^ DW'(55));
    chk("post_v", DW'(Data_valid), DW'(1));
    chk("post_empty", DW'(Empty_out), DW'(1));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
